// File: rtl/rv_ctrl_pkg.sv
// ============================================================================
// rv_ctrl_pkg : shared state, opcode and datapath-select encodings for the
//               multicycle RV32I control unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_BRANCH   = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Branch condition from funct3; the two unassigned encodings never branch.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_alu_decoder.sv
// ============================================================================
// rv_alu_decoder : combinational ALUOp/funct3/funct7_5/op[5] -> alu_control.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module rv_alu_decoder
  import rv_ctrl_pkg::*;
(
  input  aluop_t      alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        op5,
  output logic [3:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi has immediate bits in instr[30], so only register ops may subtract
          3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// multicycle_control_unit : RV32I multicycle control FSM driving every
//   datapath mux/enable. Optional ILLEGAL_INSN_EN adds a sticky TRAP state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [IMMSRC_W-1:0]  imm_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 instr_done,
  output logic                 illegal_insn
);

  state_t      r_state;
  state_t      w_next_state;
  aluop_t      w_alu_op;
  logic [3:0]  w_alu_control;
  logic [2:0]  w_imm_src;
  logic        w_mem_req, w_mem_write, w_ir_write, w_pc_write, w_reg_write;
  logic        w_instr_done, w_illegal;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    adr_src      = 1'b0;
    result_src   = RES_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RD2;
    w_imm_src    = IMM_I;
    w_alu_op     = ALUOP_ADD;

    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch/jal target into ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        w_imm_src = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXECR;
          OP_ITYPE, OP_LUI:  w_next_state = S_EXECI;
          OP_JAL:            w_next_state = S_JAL;
          OP_JALR:           w_next_state = S_JALR;
          OP_BRANCH:         w_next_state = S_BRANCH;
`ifdef ILLEGAL_INSN_EN
          default:           w_next_state = S_TRAP;
`else
          default:           w_next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a    = SRCA_RD1;
        alu_src_b    = SRCB_IMM;
        w_imm_src    = (op == OP_STORE) ? IMM_S : IMM_I;
        w_next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        result_src   = RES_DATA;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req    = 1'b1;
        w_mem_write  = 1'b1;
        adr_src      = 1'b1;
        w_instr_done = mem_ready;
        if (mem_ready) w_next_state = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a    = SRCA_RD1;
        alu_src_b    = SRCB_RD2;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_b = SRCB_IMM;
        if (op == OP_LUI) begin
          alu_src_a = SRCA_ZERO;
          w_imm_src = IMM_U;
        end else begin
          alu_src_a = SRCA_RD1;
          w_alu_op  = ALUOP_FUNCT;
        end
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JALR: begin
        alu_src_a    = SRCA_RD1;
        alu_src_b    = SRCB_IMM;
        w_next_state = S_JAL;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms the link address
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        w_pc_write   = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a    = SRCA_RD1;
        alu_src_b    = SRCB_RD2;
        w_alu_op     = ALUOP_SUB;
        w_pc_write   = branch_taken(funct3, zero, lt, ltu);
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end
`ifdef ILLEGAL_INSN_EN
      S_TRAP: begin
        w_illegal    = 1'b1;
        w_next_state = S_TRAP;
      end
`endif
      default: w_next_state = S_FETCH;
    endcase
  end

  rv_alu_decoder u_alu_decoder (
    .alu_op      (w_alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .op5         (op[5]),
    .alu_control (w_alu_control)
  );

  // Reset suppresses every side effect in the same cycle it is asserted
  assign mem_req      = w_mem_req    & ~reset;
  assign mem_write    = w_mem_write  & ~reset;
  assign ir_write     = w_ir_write   & ~reset;
  assign pc_write     = w_pc_write   & ~reset;
  assign reg_write    = w_reg_write  & ~reset;
  assign instr_done   = w_instr_done & ~reset;
  assign illegal_insn = w_illegal    & ~reset;
  assign imm_src      = IMMSRC_W'(w_imm_src);
  assign alu_control  = ALUCTRL_W'(w_alu_control);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// tb_multicycle_control_unit : table-driven instruction runs with a scoreboard
//   queue, plus hand sequences for reset abort and illegal opcodes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, zero, lt, ltu, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       instr_done, illegal_insn;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALUCTRL_W(4), .IMMSRC_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .instr_done(instr_done),
    .illegal_insn(illegal_insn)
  );

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, lt, ltu;
    int         waits;   // mem_ready-low cycles before every memory access completes
    int         cycles;
    int         alu;     // alu_control in the first cycle after DECODE
    int         pcw;
    int         rw;
    int         mw;
    int         rs_wb;   // result_src when reg_write is high
    int         pcw_rs;  // result_src at the last pc_write cycle
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];

  function automatic vec_t mk(logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                              logic l, logic lu, int w, int cy, int a, int pcw,
                              int rw, int mw, int rswb, int pcwrs);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.lt = l; v.ltu = lu; v.waits = w;
    v.cycles = cy; v.alu = a; v.pcw = pcw; v.rw = rw; v.mw = mw;
    v.rs_wb = rswb; v.pcw_rs = pcwrs;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_instr(input int idx, input vec_t v);
    int cyc = 0, waits_left = v.waits;
    int n_ir = 0, n_pcw = 0, n_rw = 0, n_mw = 0;
    int alu_at = -1, rs_wb = 0, pcw_rs = -1;
    bit done = 1'b0;
    vec_t e;
    sb_q.push_back(v);
    while (!done && cyc < 40) begin
      @(negedge clk);
      op = v.op; funct3 = v.f3; funct7_5 = v.f7;
      zero = v.z; lt = v.lt; ltu = v.ltu; mem_ready = 1'b0;
      #1;
      if (mem_req) begin
        if (waits_left == 0) mem_ready = 1'b1;
        else waits_left--;
      end
      #1;
      cyc++;
      if (ir_write) n_ir++;
      if (pc_write) begin n_pcw++; pcw_rs = int'(result_src); end
      if (reg_write) begin n_rw++; rs_wb = int'(result_src); end
      if (mem_write && mem_ready) n_mw++;
      if (cyc == v.waits + 3) alu_at = int'(alu_control);
      if (mem_ready) waits_left = v.waits;
      if (instr_done) done = 1'b1;
    end
    e = sb_q.pop_front();
    if (!done) check($sformatf("v%0d timeout", idx), 0, 1);
    check($sformatf("v%0d cycles", idx), cyc, e.cycles);
    check($sformatf("v%0d ir_write", idx), n_ir, 1);
    check($sformatf("v%0d alu_control", idx), alu_at, e.alu);
    check($sformatf("v%0d pc_write", idx), n_pcw, e.pcw);
    check($sformatf("v%0d pcw_result_src", idx), pcw_rs, e.pcw_rs);
    check($sformatf("v%0d reg_write", idx), n_rw, e.rw);
    if (e.rw > 0) check($sformatf("v%0d wb_result_src", idx), rs_wb, e.rs_wb);
    check($sformatf("v%0d mem_write", idx), n_mw, e.mw);
  endtask

  initial begin
    //              op     f3  f7 z  lt ltu w cyc alu pcw rw mw rswb pcwrs
    tbl.push_back(mk(7'h33, 3'd0, 1, 0, 0, 0, 0, 4, 1, 1, 1, 0, 0, 2)); // sub
    tbl.push_back(mk(7'h33, 3'd0, 0, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 2)); // add
    tbl.push_back(mk(7'h13, 3'd0, 1, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 2)); // addi, bit30 set
    tbl.push_back(mk(7'h13, 3'd5, 1, 0, 0, 0, 0, 4, 9, 1, 1, 0, 0, 2)); // srai
    tbl.push_back(mk(7'h13, 3'd5, 0, 0, 0, 0, 0, 4, 8, 1, 1, 0, 0, 2)); // srli
    tbl.push_back(mk(7'h33, 3'd2, 0, 0, 0, 0, 0, 4, 5, 1, 1, 0, 0, 2)); // slt
    tbl.push_back(mk(7'h13, 3'd3, 0, 0, 0, 0, 0, 4, 6, 1, 1, 0, 0, 2)); // sltiu
    tbl.push_back(mk(7'h33, 3'd7, 0, 0, 0, 0, 0, 4, 2, 1, 1, 0, 0, 2)); // and
    tbl.push_back(mk(7'h13, 3'd6, 0, 0, 0, 0, 0, 4, 3, 1, 1, 0, 0, 2)); // ori
    tbl.push_back(mk(7'h33, 3'd4, 0, 0, 0, 0, 0, 4, 4, 1, 1, 0, 0, 2)); // xor
    tbl.push_back(mk(7'h33, 3'd1, 0, 0, 0, 0, 0, 4, 7, 1, 1, 0, 0, 2)); // sll
    tbl.push_back(mk(7'h37, 3'd5, 1, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 2)); // lui
    tbl.push_back(mk(7'h6F, 3'd0, 0, 0, 0, 0, 0, 4, 0, 2, 1, 0, 0, 0)); // jal
    tbl.push_back(mk(7'h67, 3'd0, 0, 0, 0, 0, 0, 5, 0, 2, 1, 0, 0, 0)); // jalr
    tbl.push_back(mk(7'h63, 3'd0, 0, 1, 0, 0, 0, 3, 1, 2, 0, 0, 0, 0)); // beq taken
    tbl.push_back(mk(7'h63, 3'd1, 0, 0, 0, 0, 0, 3, 1, 2, 0, 0, 0, 0)); // bne taken
    tbl.push_back(mk(7'h63, 3'd1, 0, 1, 0, 0, 0, 3, 1, 1, 0, 0, 0, 2)); // bne not
    tbl.push_back(mk(7'h63, 3'd4, 0, 0, 1, 0, 0, 3, 1, 2, 0, 0, 0, 0)); // blt taken
    tbl.push_back(mk(7'h63, 3'd5, 0, 0, 1, 0, 0, 3, 1, 1, 0, 0, 0, 2)); // bge not
    tbl.push_back(mk(7'h63, 3'd6, 0, 0, 0, 1, 0, 3, 1, 2, 0, 0, 0, 0)); // bltu taken
    tbl.push_back(mk(7'h63, 3'd7, 0, 0, 0, 1, 0, 3, 1, 1, 0, 0, 0, 2)); // bgeu not
    tbl.push_back(mk(7'h63, 3'd2, 0, 1, 1, 1, 0, 3, 1, 1, 0, 0, 0, 2)); // f3=010 never
    tbl.push_back(mk(7'h63, 3'd3, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 2)); // f3=011 never
    tbl.push_back(mk(7'h03, 3'd2, 0, 0, 0, 0, 0, 5, 0, 1, 1, 0, 1, 2)); // lw
    tbl.push_back(mk(7'h03, 3'd2, 0, 0, 0, 0, 2, 9, 0, 1, 1, 0, 1, 2)); // lw, 2 waits
    tbl.push_back(mk(7'h23, 3'd2, 0, 0, 0, 0, 0, 4, 0, 1, 0, 1, 0, 2)); // sw
    tbl.push_back(mk(7'h23, 3'd2, 0, 0, 0, 0, 1, 6, 0, 1, 0, 1, 0, 2)); // sw, 1 wait
    tbl.push_back(mk(7'h33, 3'd0, 0, 0, 0, 0, 1, 5, 0, 1, 1, 0, 0, 2)); // add, 1 wait

    reset = 1'b1; op = 7'h33; funct3 = 3'd0; funct7_5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset mem_req", int'(mem_req), 0);
    check("reset ir_write", int'(ir_write), 0);
    check("reset pc_write", int'(pc_write), 0);
    check("reset instr_done", int'(instr_done), 0);
    check("reset illegal_insn", int'(illegal_insn), 0);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_instr(i, tbl[i]);

    // Reset while a store is waiting on memory
    begin
      int guard = 0;
      op = 7'h23; funct3 = 3'd2;
      while (!mem_write && guard < 20) begin
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        if (mem_req && !mem_write) mem_ready = 1'b1;
        #1;
        guard++;
      end
      check("store reached", int'(mem_write), 1);
      reset = 1'b1;
      #1;
      check("rst mem_write", int'(mem_write), 0);
      check("rst mem_req", int'(mem_req), 0);
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b0;
      #1;
      check("post-rst mem_req", int'(mem_req), 1);
      check("post-rst adr_src", int'(adr_src), 0);
      check("post-rst srcB", int'(alu_src_b), 2);
      check("post-rst mem_write", int'(mem_write), 0);
    end

    // Unknown opcode
    @(negedge clk);
    op = 7'h7F; mem_ready = 1'b1;
    #1;
    check("ill fetch ir_write", int'(ir_write), 1);
    @(negedge clk);
    #1;
    check("ill decode mem_req", int'(mem_req), 0);
`ifdef ILLEGAL_INSN_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("trap%0d illegal", k), int'(illegal_insn), 1);
      check($sformatf("trap%0d mem_req", k), int'(mem_req), 0);
      check($sformatf("trap%0d pc_write", k), int'(pc_write), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    check("trap exit illegal", int'(illegal_insn), 0);
    check("trap exit mem_req", int'(mem_req), 1);
`else
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("nop back to fetch", int'(mem_req), 1);
    check("nop illegal", int'(illegal_insn), 0);
    check("nop reg_write", int'(reg_write), 0);
`endif

    // One more instruction after the corner cases to show recovery
    run_instr(100, mk(7'h33, 3'd0, 1, 0, 0, 0, 0, 4, 1, 1, 1, 0, 0, 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
